// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencer/arbiter.
// Holds the FSM state encoding and operation codes.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        CHECK
    } state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grant.
// The pointer records the last winner; reset favours requester A.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1: B won last, so A wins the next tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|gnt)) begin
            ptr_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Arbitrates two requesters onto a bank of gated SR latches and
// sequences setup, enable, hold and readback for each command.
module sr_latch_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N_LATCH   = 4,
    parameter int EN_CYCLES = 2,
    localparam int IDX_W    = $clog2(N_LATCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               op_a,
    input  logic [IDX_W-1:0]   idx_a,
    output logic               gnt_a,
    input  logic               req_b,
    input  logic               op_b,
    input  logic [IDX_W-1:0]   idx_b,
    output logic               gnt_b,
    output logic [N_LATCH-1:0] s,
    output logic [N_LATCH-1:0] r,
    output logic [N_LATCH-1:0] e,
    input  logic [N_LATCH-1:0] q_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CNT_W = $clog2(EN_CYCLES + 1);
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_LATCH);
    localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(EN_CYCLES - 1);

    if (EN_CYCLES < 1) begin : g_bad_en
        $error("EN_CYCLES must be at least 1");
    end
    if (N_LATCH < 2 || N_LATCH > 16) begin : g_bad_n
        $error("N_LATCH must be in 2..16");
    end

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]         gnt_w;
    logic               arb_adv;
    logic               win_op;
    logic [IDX_W-1:0]   win_idx;
    logic               rng_q;
    logic [N_LATCH-1:0] sel;
    logic               rb;
    logic               gnt_a_c;
    logic               gnt_b_c;

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return {1'b0, i} < N_LIM;
    endfunction

    assign arb_adv = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req_b, req_a}),
        .advance (arb_adv),
        .gnt     (gnt_w)
    );

    assign win_op  = gnt_w[1] ? op_b  : op_a;
    assign win_idx = gnt_w[1] ? idx_b : idx_a;
    assign rng_q   = in_range(idx_q);

    // Out-of-range indices decode to no latch at all
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            sel[i] = rng_q && (idx_q == IDX_W'(i));
        end
    end

    assign rb = |(q_in & sel);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_a_c = 1'b0;
        gnt_b_c = 1'b0;
        s       = '0;
        r       = '0;
        e       = '0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt_w) begin
                    gnt_a_c = gnt_w[0];
                    gnt_b_c = gnt_w[1];
                    op_d    = win_op;
                    idx_d   = win_idx;
                    state_d = in_range(win_idx) ? SETUP : CHECK;
                end
            end
            SETUP: begin
                s       = op_q ? sel : '0;
                r       = op_q ? '0 : sel;
                cnt_d   = CNT_LD;
                state_d = ENABLE;
            end
            ENABLE: begin
                s = op_q ? sel : '0;
                r = op_q ? '0 : sel;
                e = sel;
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                s       = op_q ? sel : '0;
                r       = op_q ? '0 : sel;
                state_d = CHECK;
            end
            CHECK: begin
                done    = 1'b1;
                err     = !rng_q || (rb != op_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants must vanish the instant reset asserts
    assign gnt_a = gnt_a_c & rst_n;
    assign gnt_b = gnt_b_c & rst_n;
    assign busy  = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_RESET;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: latch model, scoreboard, vector table,
// corner-case sequences and a randomized invariant run.
module tb_sr_latch_arbiter;

    localparam int N  = 4;
    localparam int EN = 2;
    localparam int W  = 2;
    localparam int N3  = 3;
    localparam int EN3 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req_a, op_a, req_b, op_b, gnt_a, gnt_b;
    logic [W-1:0] idx_a, idx_b;
    logic [N-1:0] s, r, e, q_in;
    logic         busy, done, err;
    logic [N-1:0] q_lat = '0;
    logic [N-1:0] fault;

    logic          req3_a, op3_a, req3_b, op3_b, gnt3_a, gnt3_b;
    logic [W-1:0]  idx3_a, idx3_b;
    logic [N3-1:0] s3, r3, e3, q3_in;
    logic          busy3, done3, err3;
    logic [N3-1:0] q3_lat = '0;

    assign q_in  = q_lat ^ fault;
    assign q3_in = q3_lat;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (e[i]) begin
                if (s[i]) q_lat[i] <= 1'b1;
                else if (r[i]) q_lat[i] <= 1'b0;
            end
        for (int i = 0; i < N3; i++)
            if (e3[i]) begin
                if (s3[i]) q3_lat[i] <= 1'b1;
                else if (r3[i]) q3_lat[i] <= 1'b0;
            end
    end

    sr_latch_arbiter #(.N_LATCH(N), .EN_CYCLES(EN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .op_a(op_a), .idx_a(idx_a), .gnt_a(gnt_a),
        .req_b(req_b), .op_b(op_b), .idx_b(idx_b), .gnt_b(gnt_b),
        .s(s), .r(r), .e(e), .q_in(q_in),
        .busy(busy), .done(done), .err(err)
    );

    sr_latch_arbiter #(.N_LATCH(N3), .EN_CYCLES(EN3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req3_a), .op_a(op3_a), .idx_a(idx3_a), .gnt_a(gnt3_a),
        .req_b(req3_b), .op_b(op3_b), .idx_b(idx3_b), .gnt_b(gnt3_b),
        .s(s3), .r(r3), .e(e3), .q_in(q3_in),
        .busy(busy3), .done(done3), .err(err3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] idx;
        logic         err;
    } exp_t;
    exp_t sb[$];

    // Invariants every cycle; scoreboard push on grant, pop on done
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            chk("s_and_r", 32'(s & r), 0);
            chk("sr_onehot0", 32'($onehot0(s | r)), 1);
            chk("e_onehot0", 32'($onehot0(e)), 1);
            chk("e_in_sr", 32'(e & ~(s | r)), 0);
            chk("gnt_excl", 32'(gnt_a & gnt_b), 0);
            if (gnt_a || gnt_b) chk("gnt_in_idle", 32'(busy), 0);
            if (!done) chk("err_wo_done", 32'(err), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sb_err", 32'(err), 32'(x.err));
                    chk("sb_latch_q", 32'(q_lat[x.idx]), 32'(x.op));
                end
            end
            if (gnt_a) sb.push_back('{op_a, idx_a, fault[idx_a]});
            if (gnt_b) sb.push_back('{op_b, idx_b, fault[idx_b]});
        end
    end

    task automatic drv_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic cyc;
        drv_edge();
        smp();
    endtask

    typedef struct {
        logic         use_a;
        logic         op;
        logic [W-1:0] idx;
        logic [N-1:0] flt;
        logic [N-1:0] exp_s;
        logic [N-1:0] exp_r;
        logic         exp_err;
    } vec_t;

    task automatic run_cmd(input vec_t v);
        logic got;
        int c;
        got = 1'b0;
        drv_edge();
        fault = v.flt;
        if (v.use_a) begin
            req_a = 1'b1; op_a = v.op; idx_a = v.idx;
        end else begin
            req_b = 1'b1; op_b = v.op; idx_b = v.idx;
        end
        for (int k = 0; k < 20; k++) begin
            smp();
            if (gnt_a || gnt_b) begin
                got = 1'b1;
                break;
            end
            drv_edge();
        end
        chk("tbl_grant_seen", 32'(got), 1);
        chk("tbl_grant_side", 32'(gnt_a), 32'(v.use_a));
        drv_edge();
        req_a = 1'b0;
        req_b = 1'b0;
        smp();
        chk("tbl_setup_s", 32'(s), 32'(v.exp_s));
        chk("tbl_setup_r", 32'(r), 32'(v.exp_r));
        chk("tbl_setup_e", 32'(e), 0);
        c = 1;
        while (!done && c < 20) begin
            cyc();
            c++;
        end
        chk("tbl_latency", 32'(c), 32'(EN + 3));
        chk("tbl_err", 32'(err), 32'(v.exp_err));
        chk("tbl_latch", 32'(q_lat[v.idx]), 32'(v.op));
    endtask

    vec_t tbl[8];
    logic [N-1:0] s_exp[6];
    logic [N-1:0] e_exp[6];
    logic         last_a;
    int           last_c;
    int           n_gnt;
    int           c;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 2'd3, 4'b0000, 4'b1000, 4'b0000, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 4'b0000, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 2'd3, 4'b1000, 4'b0000, 4'b1000, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
        s_exp = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        e_exp = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};

        rst_n = 1'b0;
        req_a = 1'b1; op_a = 1'b1; idx_a = '0;
        req_b = 1'b1; op_b = 1'b0; idx_b = '0;
        fault = '0;
        req3_a = 1'b0; op3_a = 1'b0; idx3_a = '0;
        req3_b = 1'b0; op3_b = 1'b0; idx3_b = '0;
        smp();
        chk("rst_outputs", 32'({gnt_a, gnt_b, s, r, e, busy, done, err}), 0);
        drv_edge();
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;
        smp();
        chk("rst_idle", 32'(busy), 0);

        // Single set of latch 2 with cycle-exact checks
        drv_edge();
        req_a = 1'b1; op_a = 1'b1; idx_a = 2'd2;
        smp();
        chk("single_gnt_a", 32'(gnt_a), 1);
        for (int k = 1; k <= 5; k++) begin
            drv_edge();
            req_a = 1'b0;
            smp();
            chk("single_s", 32'(s), 32'(s_exp[k]));
            chk("single_r", 32'(r), 0);
            chk("single_e", 32'(e), 32'(e_exp[k]));
            chk("single_done", 32'(done), 32'(k == 5));
        end
        chk("single_err", 32'(err), 0);
        chk("single_q2", 32'(q_in[2]), 1);

        for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

        // Reset asserted in the middle of ENABLE
        drv_edge();
        fault = '0;
        req_a = 1'b1; op_a = 1'b0; idx_a = 2'd3;
        smp();
        chk("rmid_gnt", 32'(gnt_a), 1);
        drv_edge();
        req_a = 1'b0;
        smp();
        cyc();
        chk("rmid_in_enable", 32'(e), 32'(4'b1000));
        #1;
        rst_n = 1'b0;
        req_b = 1'b1;
        #1;
        chk("rmid_outputs", 32'({gnt_a, gnt_b, s, r, e, busy, done, err}), 0);
        cyc();
        drv_edge();
        req_b = 1'b0;
        rst_n = 1'b1;
        smp();
        chk("rmid_idle", 32'(busy), 0);
        for (int k = 0; k < 8; k++) cyc();

        // Continuous tie: grants must alternate every EN+4 cycles
        drv_edge();
        req_a = 1'b1; op_a = 1'b1; idx_a = 2'd0;
        req_b = 1'b1; op_b = 1'b0; idx_b = 2'd1;
        n_gnt = 0;
        last_a = 1'b0;
        last_c = 0;
        for (int k = 0; k < 40; k++) begin
            smp();
            if (gnt_a || gnt_b) begin
                if (n_gnt == 0) begin
                    chk("tie_first_a", 32'(gnt_a), 1);
                end else begin
                    chk("tie_alternate", 32'(gnt_a), 32'(!last_a));
                    chk("tie_period", 32'(k - last_c), 32'(EN + 4));
                end
                n_gnt++;
                last_a = gnt_a;
                last_c = k;
            end
            drv_edge();
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("tie_grant_count", 32'(n_gnt >= 6), 1);
        c = 0;
        smp();
        while (busy && c < 20) begin
            cyc();
            c++;
        end
        chk("tie_drain", 32'(busy), 0);

        // Out-of-range index on the 3-latch instance
        drv_edge();
        req3_b = 1'b1; op3_b = 1'b1; idx3_b = 2'd3;
        smp();
        chk("oor_gnt_b", 32'(gnt3_b), 1);
        chk("oor_t_sre", 32'({s3, r3, e3}), 0);
        drv_edge();
        req3_b = 1'b0;
        smp();
        chk("oor_done", 32'(done3), 1);
        chk("oor_err", 32'(err3), 1);
        chk("oor_t1_sre", 32'({s3, r3, e3}), 0);
        cyc();
        chk("oor_idle", 32'({busy3, done3}), 0);

        drv_edge();
        req3_a = 1'b1; op3_a = 1'b1; idx3_a = 2'd2;
        smp();
        chk("n3_gnt_a", 32'(gnt3_a), 1);
        drv_edge();
        req3_a = 1'b0;
        smp();
        c = 1;
        while (!done3 && c < 20) begin
            cyc();
            c++;
        end
        chk("n3_latency", 32'(c), 32'(EN3 + 3));
        chk("n3_err", 32'(err3), 0);
        chk("n3_q2", 32'(q3_lat), 32'(3'b100));

        // Random requests with occasional asynchronous resets
        for (int k = 0; k < 1200; k++) begin
            drv_edge();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_outputs",
                    32'({gnt_a, gnt_b, s, r, e, busy, done, err}), 0);
            end else begin
                rst_n = 1'b1;
            end
            req_a = ($urandom_range(0, 2) != 0);
            op_a  = 1'($urandom_range(0, 1));
            idx_a = W'($urandom_range(0, N - 1));
            req_b = ($urandom_range(0, 2) != 0);
            op_b  = 1'($urandom_range(0, 1));
            idx_b = W'($urandom_range(0, N - 1));
            smp();
        end
        drv_edge();
        rst_n = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        smp();
        c = 0;
        while (busy && c < 20) begin
            cyc();
            c++;
        end
        chk("rnd_drain", 32'(busy), 0);
        cyc();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_arbiter.md
Name: sr_latch_arbiter

Overview:
- Sequencer and 2-way arbiter that shares a bank of N gated SR latches (inputs s, r, e; output q) between two requesters.
- Accepts set/reset commands, grants them round-robin, and drives each latch's s/r/e with a safe setup → enable → hold sequence.
- Never drives s=r=1 on any latch. After each command it reads the latch back and flags any mismatch.
- Sits between control logic and the latch bank; it is the only driver of the latch inputs.

Parameters:
- N_LATCH, 4, number of latches in the bank (2..16).
- EN_CYCLES, 2, cycles the enable is held high per command (≥1; 0 is an elaboration error).
- IDX_W, $clog2(N_LATCH), derived width of the latch index; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_a  in  1  requester A command request; held until gnt_a
- op_a  in  1  A operation: 1=set, 0=reset
- idx_a  in  IDX_W  A target latch index
- gnt_a  out  1  one-cycle grant to A; command captured this cycle
- req_b, op_b, idx_b, gnt_b  same as A, for requester B
- s  out  N_LATCH  per-latch set inputs
- r  out  N_LATCH  per-latch reset inputs
- e  out  N_LATCH  per-latch enable inputs
- q_in  in  N_LATCH  latch q readback
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse with done if readback ≠ op or idx out of range

Behaviour:
- Reset (rst_n low, async): s=r=e=0, gnt_a=gnt_b=0, busy=done=err=0, state=IDLE, last-grant pointer=B (A wins first tie). Latches keep their contents.
- Reset mid-operation: all outputs drop to 0 immediately. The in-flight command is discarded with no done.

FSM states: IDLE, SETUP, ENABLE, HOLD, CHECK.
- IDLE: if any req is high, grant one (round-robin on tie, otherwise the sole requester).
  - Assert gnt_x for that cycle and capture op/idx.
  - Toggle the pointer to the winner.
  - Go to SETUP, or to CHECK if idx ≥ N_LATCH.
  - With no request, remain in IDLE with all outputs 0.
- SETUP (1 cycle): s[idx]=op, r[idx]=~op, e=0.
- ENABLE (EN_CYCLES cycles): same s/r, e[idx]=1. A down-counter reloads on entry.
- HOLD (1 cycle): e=0, s/r unchanged, so data is stable across the enable's falling edge.
- CHECK (1 cycle): s=r=e=0; done=1.
  - err=1 if idx ≥ N_LATCH, or if q_in[idx] ≠ op.
  - Go to IDLE.
- Latency: grant at cycle T → enable high T+2..T+1+EN_CYCLES → done at T+3+EN_CYCLES. Back-to-back issue period is EN_CYCLES+4 cycles.

Invariants (must hold every cycle):
- s & r == 0.
- At most one bit of s|r is set, and at most one bit of e.
- e bit ⊆ s|r bit.
- gnt_a & gnt_b == 0.
- Grants occur only in IDLE.

Request and grant rules:
- Requests arriving while busy are ignored until IDLE; the requester keeps req high.
- Dropping req before grant withdraws the request; no error.
- A and B targeting the same idx is legal: the commands serialize and the last-granted command wins.
- Out-of-range idx: no latch input is touched; done and err are both asserted.

Decomposition:
- Package sr_ctrl_pkg: state enum typedef (IDLE, SETUP, ENABLE, HOLD, CHECK), constants OP_SET=1'b1 and OP_RESET=1'b0.
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt.
  - Contains the pointer register, reset to favour A.

Test Plan:
- Reset: assert rst_n=0 mid-ENABLE → s/r/e/gnt/busy/done/err all 0 in the same cycle; after release, state is IDLE.
- Single set: EN_CYCLES=2, req_a=1, op_a=1, idx_a=2, bench latch model → gnt_a at T; s=4'b0100 T+1..T+4; e=4'b0100 at T+2,T+3; done=1, err=0 at T+5; q_in[2]=1.
- Tie alternation: req_a and req_b held high continuously (A: set idx0, B: reset idx1) → grants alternate A,B,A,B every 6 cycles; never both grants high.
- Readback fault: force q_in[1]=0 while setting idx 1 → done and err pulse together at T+5.
- Out-of-range: N_LATCH=3, idx_b=3 → gnt_b, s=r=e=0 throughout, done=err=1 at T+1.
- Invariant monitor: 1000 random requests/ops/indices plus random resets → s&r==0 and single-hot e hold in every cycle.
